calc_gravity_divider: RTL and testbench
=======================================

// Module: calc_gravity_divider
// PURPOSE
//  Consumer end of the center-of-gravity accumulators.
//  - Takes the per-frame weighted sum (sum of data*position) and mass sum (sum of data).
//  - Computes coordinate = floor(weighted / mass) with a sequential restoring divider, one quotient bit per clock.
//  - Presents the result on a valid/ready output to the eye-position logic.
//  - One instance per axis (X, Y).
// PARAMETERS
//  SUM_WIDTH    16  width of weighted-sum input (dividend) and of the internal quotient
//  MASS_WIDTH   16  width of mass-sum input (divisor)
//  COORD_WIDTH  10  width of output coordinate; must be <= SUM_WIDTH
// PORTS
//  CCLK     in   1            system clock, all logic on rising edge
//  RST_N    in   1            asynchronous active-low reset
//  iSTART   in   1            one-cycle pulse: latch iSUM/iMASS and start a division
//  iSUM     in   SUM_WIDTH    weighted sum (dividend), unsigned
//  iMASS    in   MASS_WIDTH   mass sum (divisor), unsigned
//  oBUSY    out  1            high while a division is running or a result awaits acceptance
//  oVALID   out  1            result valid
//  iREADY   in   1            downstream accepts the result when oVALID && iREADY
//  oCOORD   out  COORD_WIDTH  quotient, saturated
//  oZERO    out  1            divisor was 0; oCOORD forced to 0 (qualified by oVALID)
//  oOVF     out  1            quotient exceeded 2^COORD_WIDTH-1; oCOORD saturated (qualified by oVALID)
// BEHAVIOUR
//  Reset
//  - Asynchronous reset clears: state=IDLE, oBUSY=0, oVALID=0, oCOORD=0, oZERO=0, oOVF=0, and all internal registers.
//  - Reset may assert at any time. An in-flight division is discarded; no result is produced.
//  FSM: IDLE -> DIV -> DONE -> IDLE
//  - IDLE: iSTART=1 latches iSUM into the dividend and iMASS into the divisor, then goes to DIV.
//    Remainder is cleared, bit counter is set to SUM_WIDTH-1. oBUSY rises the following cycle.
//  - DIV, mass != 0 (one step per cycle, SUM_WIDTH cycles total):
//    - Shift remainder left by 1 and bring in the dividend MSB.
//    - If remainder >= divisor: subtract the divisor and shift 1 into the quotient; else shift 0.
//    - Remainder is MASS_WIDTH+1 bits so the compare never loses a carry.
//    - After the step with counter==0, go to DONE.
//  - DIV, mass == 0: skip iteration. Go straight to DONE on the next edge with quotient=0 and oZERO=1.
//  - DONE: oVALID=1 and outputs are stable. oVALID && iREADY returns to IDLE; oVALID falls on that edge.
//    Outputs hold until the next result. Only oVALID qualifies them.
//  Latency
//  - iSTART sampled at edge N; mass != 0 gives oVALID high after edge N+SUM_WIDTH+1; mass == 0 gives oVALID after edge N+2.
//  - Back-to-back: iSTART on the same cycle as the accepting handshake is ignored (state is not IDLE). Earliest new start is the cycle after.
//  Width rules
//  - Quotient is SUM_WIDTH bits internally.
//  - If any bit at or above COORD_WIDTH is set: oCOORD = all ones and oOVF=1. Otherwise oCOORD = quotient[COORD_WIDTH-1:0] and oOVF=0.
//  - oZERO and oOVF are mutually exclusive.
//  - Truncation only, no rounding.
//  Boundary cases
//  - iSTART while oBUSY=1 is dropped silently. Latched operands are not disturbed.
//  - iREADY while oVALID=0 has no effect.
//  - iSUM=0 with mass != 0 gives oCOORD=0, oZERO=0, oOVF=0.
//  - iSUM/iMASS are sampled only on an accepted iSTART and may change freely afterwards.
// STRUCTURE
//  - Shared package/header: FSM state encodings (IDLE=2'd0, DIV=2'd1, DONE=2'd2) and default widths shared with the accumulator block.
//  - Single module. The restoring-division step (compare/subtract/shift) may be a combinational function inside it.
//  - No sub-module required.
// TESTING
//  1. iSUM=1000, iMASS=10, iREADY=1 -> oVALID after 17 cycles, oCOORD=100, oZERO=0, oOVF=0.
//  2. iSUM=1234, iMASS=0 -> oVALID 2 cycles after start, oCOORD=0, oZERO=1.
//  3. iSUM=65535, iMASS=1 -> oCOORD=1023, oOVF=1. Then iSUM=1023, iMASS=1 -> oCOORD=1023, oOVF=0.
//  4. iSUM=999, iMASS=7, iREADY=0 for 20 cycles -> oVALID and oCOORD=142 held stable; one cycle of iREADY=1 -> oVALID=0 next edge.
//  5. iSUM=500, iMASS=5 started, iSTART with iSUM=9, iMASS=3 at cycle 5 -> result 100 only; the second start is ignored.
//  6. RST_N low at cycle 8 of a division -> all outputs 0 immediately; no oVALID after release until a new iSTART.

Source files
------------

// File: rtl/calc_gravity_pkg.sv
// Shared definitions for the centre-of-gravity accumulator and divider blocks:
// divider FSM encodings and the default datapath widths.
package calc_gravity_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_DONE = 2'd2
  } cgd_state_e;

  localparam int unsigned CG_SUM_WIDTH   = 16;
  localparam int unsigned CG_MASS_WIDTH  = 16;
  localparam int unsigned CG_COORD_WIDTH = 10;

endpackage

// File: rtl/calc_gravity_divider.sv
// Per-axis centre-of-gravity divider: coordinate = floor(weighted / mass) using a
// restoring divider (one quotient bit per clock), result on a valid/ready port.
//
// state   | meaning
// --------+------------------------------------------------------------------
// ST_IDLE | waiting for iSTART; operands latched on the starting edge
// ST_DIV  | one restoring step per cycle; zero divisor skips straight to DONE
// ST_DONE | first cycle registers the result, then holds oVALID until iREADY
module calc_gravity_divider
  import calc_gravity_pkg::*;
#(
  parameter int unsigned SUM_WIDTH   = CG_SUM_WIDTH,
  parameter int unsigned MASS_WIDTH  = CG_MASS_WIDTH,
  parameter int unsigned COORD_WIDTH = CG_COORD_WIDTH
) (
  input  logic                   CCLK,
  input  logic                   RST_N,
  input  logic                   iSTART,
  input  logic [SUM_WIDTH-1:0]   iSUM,
  input  logic [MASS_WIDTH-1:0]  iMASS,
  output logic                   oBUSY,
  output logic                   oVALID,
  input  logic                   iREADY,
  output logic [COORD_WIDTH-1:0] oCOORD,
  output logic                   oZERO,
  output logic                   oOVF
);

  localparam int CNT_W = (SUM_WIDTH > 1) ? $clog2(SUM_WIDTH) : 1;

  cgd_state_e             state_q, state_d;
  logic [SUM_WIDTH-1:0]   dividend_q, dividend_d;
  logic [MASS_WIDTH-1:0]  divisor_q, divisor_d;
  logic [MASS_WIDTH-1:0]  rem_q, rem_d;
  logic [SUM_WIDTH-1:0]   quot_q, quot_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   busy_q, busy_d;
  logic                   valid_q, valid_d;
  logic [COORD_WIDTH-1:0] coord_q, coord_d;
  logic                   zero_q, zero_d;
  logic                   ovf_q, ovf_d;

  logic [MASS_WIDTH:0]    step_res;
  logic                   quot_ovf;
  logic                   div_by_zero;

  // Restoring step: returns {quotient bit, new remainder}. The trial value is one
  // bit wider than the divisor so the shifted-in remainder never loses its carry;
  // after a successful subtract the remainder is below the divisor again.
  function automatic logic [MASS_WIDTH:0] div_step(
    input logic [MASS_WIDTH-1:0] rem,
    input logic                  bit_in,
    input logic [MASS_WIDTH-1:0] dvs
  );
    logic [MASS_WIDTH:0] trial;
    trial = {rem, bit_in};
    if (trial >= {1'b0, dvs}) begin
      div_step = {1'b1, MASS_WIDTH'(trial - {1'b0, dvs})};
    end else begin
      div_step = {1'b0, trial[MASS_WIDTH-1:0]};
    end
  endfunction

  assign step_res    = div_step(rem_q, dividend_q[SUM_WIDTH-1], divisor_q);
  assign quot_ovf    = |(quot_q >> COORD_WIDTH);
  assign div_by_zero = (divisor_q == '0);

  always_comb begin
    state_d    = state_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    rem_d      = rem_q;
    quot_d     = quot_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    valid_d    = valid_q;
    coord_d    = coord_q;
    zero_d     = zero_q;
    ovf_d      = ovf_q;

    case (state_q)
      ST_IDLE: begin
        if (iSTART) begin
          dividend_d = iSUM;
          divisor_d  = iMASS;
          rem_d      = '0;
          quot_d     = '0;
          cnt_d      = CNT_W'(SUM_WIDTH - 1);
          busy_d     = 1'b1;
          state_d    = ST_DIV;
        end
      end

      ST_DIV: begin
        if (div_by_zero) begin
          quot_d  = '0;
          state_d = ST_DONE;
        end else begin
          rem_d      = step_res[MASS_WIDTH-1:0];
          quot_d     = {quot_q[SUM_WIDTH-2:0], step_res[MASS_WIDTH]};
          dividend_d = {dividend_q[SUM_WIDTH-2:0], 1'b0};
          cnt_d      = cnt_q - CNT_W'(1);
          if (cnt_q == '0) begin
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        // Result flags are registered on the first DONE cycle so they change
        // together with oVALID and then hold until the next result.
        if (!valid_q) begin
          valid_d = 1'b1;
          zero_d  = div_by_zero;
          ovf_d   = quot_ovf && !div_by_zero;
          if (div_by_zero) begin
            coord_d = '0;
          end else if (quot_ovf) begin
            coord_d = '1;
          end else begin
            coord_d = quot_q[COORD_WIDTH-1:0];
          end
        end else if (iREADY) begin
          valid_d = 1'b0;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CCLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= ST_IDLE;
      dividend_q <= '0;
      divisor_q  <= '0;
      rem_q      <= '0;
      quot_q     <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      coord_q    <= '0;
      zero_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      rem_q      <= rem_d;
      quot_q     <= quot_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
      coord_q    <= coord_d;
      zero_q     <= zero_d;
      ovf_q      <= ovf_d;
    end
  end

  assign oBUSY  = busy_q;
  assign oVALID = valid_q;
  assign oCOORD = coord_q;
  assign oZERO  = zero_q;
  assign oOVF   = ovf_q;

endmodule

// File: tb/tb_calc_gravity_divider.sv
// Scoreboard bench for calc_gravity_divider: expected results are queued at
// launch and compared when the divider hands a result over.
module tb_calc_gravity_divider;

  localparam int unsigned SW = 16;
  localparam int unsigned MW = 16;
  localparam int unsigned CW = 10;
  localparam int unsigned MAX_COORD = (1 << CW) - 1;

  logic          CCLK = 1'b0;
  logic          RST_N;
  logic          iSTART;
  logic [SW-1:0] iSUM;
  logic [MW-1:0] iMASS;
  logic          oBUSY;
  logic          oVALID;
  logic          iREADY;
  logic [CW-1:0] oCOORD;
  logic          oZERO;
  logic          oOVF;

  typedef struct {
    int unsigned coord;
    bit          zero;
    bit          ovf;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned cyc = 0;
  int unsigned start_cyc = 0;

  calc_gravity_divider #(
    .SUM_WIDTH  (SW),
    .MASS_WIDTH (MW),
    .COORD_WIDTH(CW)
  ) dut (
    .CCLK  (CCLK),
    .RST_N (RST_N),
    .iSTART(iSTART),
    .iSUM  (iSUM),
    .iMASS (iMASS),
    .oBUSY (oBUSY),
    .oVALID(oVALID),
    .iREADY(iREADY),
    .oCOORD(oCOORD),
    .oZERO (oZERO),
    .oOVF  (oOVF)
  );

  always #5 CCLK = ~CCLK;

  always @(posedge CCLK) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input int unsigned sum, input int unsigned mass);
    exp_t e;
    int unsigned q;
    if (mass == 0) begin
      e.coord = 0; e.zero = 1'b1; e.ovf = 1'b0;
    end else begin
      q = sum / mass;
      e.zero = 1'b0;
      e.ovf  = (q > MAX_COORD);
      e.coord = e.ovf ? MAX_COORD : q;
    end
    return e;
  endfunction

  // Handshake completes on the next rising edge; compare the result now.
  always @(negedge CCLK) begin
    if (RST_N && oVALID && iREADY) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_result", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_eq("coord", 32'(oCOORD), e.coord);
        check_eq("zero", 32'(oZERO), 32'(e.zero));
        check_eq("ovf", 32'(oOVF), 32'(e.ovf));
      end
    end
  end

  task automatic tick();
    @(posedge CCLK);
    #1;
  endtask

  task automatic launch(input int unsigned sum, input int unsigned mass, input bit push);
    iSTART = 1'b1;
    iSUM   = SW'(sum);
    iMASS  = MW'(mass);
    if (push) sb.push_back(model(sum, mass));
    tick();
    start_cyc = cyc;
    iSTART = 1'b0;
    iSUM   = $urandom();
    iMASS  = $urandom();
    check_eq("busy_rise", 32'(oBUSY), 1);
  endtask

  task automatic wait_valid(input string tag, input int unsigned exp_lat);
    int unsigned n = 0;
    while (!oVALID && n < 60) begin
      tick();
      n++;
    end
    if (!oVALID) check_eq({tag, "_timeout"}, 0, 1);
    else         check_eq({tag, "_latency"}, cyc - start_cyc, exp_lat);
  endtask

  task automatic run_one(input string tag, input int unsigned sum, input int unsigned mass);
    launch(sum, mass, 1'b1);
    wait_valid(tag, (mass == 0) ? 2 : SW + 1);
    tick();
    check_eq({tag, "_valid_drop"}, 32'(oVALID), 0);
  endtask

  initial begin
    int unsigned held_coord;
    bit          saw_valid;

    RST_N  = 1'b0;
    iSTART = 1'b0;
    iSUM   = '0;
    iMASS  = '0;
    iREADY = 1'b1;
    repeat (3) tick();
    RST_N = 1'b1;
    tick();
    check_eq("rst_busy", 32'(oBUSY), 0);
    check_eq("rst_valid", 32'(oVALID), 0);
    check_eq("rst_coord", 32'(oCOORD), 0);
    check_eq("rst_zero", 32'(oZERO), 0);
    check_eq("rst_ovf", 32'(oOVF), 0);

    run_one("t1", 1000, 10);
    run_one("t2", 1234, 0);
    run_one("t3a", 65535, 1);
    run_one("t3b", 1023, 1);
    run_one("sum0", 0, 5);
    run_one("max_mass", 65535, 65535);

    // Result held while downstream stalls.
    iREADY = 1'b0;
    launch(999, 7, 1'b1);
    wait_valid("t4", SW + 1);
    held_coord = 32'(oCOORD);
    check_eq("t4_coord", held_coord, 142);
    for (int i = 0; i < 20; i++) begin
      tick();
      check_eq("t4_hold_valid", 32'(oVALID), 1);
      check_eq("t4_hold_coord", 32'(oCOORD), held_coord);
    end
    iREADY = 1'b1;
    tick();
    check_eq("t4_valid_drop", 32'(oVALID), 0);
    check_eq("t4_busy_drop", 32'(oBUSY), 0);

    // Start during a running division is dropped.
    launch(500, 5, 1'b1);
    repeat (4) tick();
    iSTART = 1'b1; iSUM = 16'd9; iMASS = 16'd3;
    tick();
    iSTART = 1'b0;
    wait_valid("t5", SW + 1);
    tick();
    saw_valid = 1'b0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (oVALID) saw_valid = 1'b1;
    end
    check_eq("t5_no_second", 32'(saw_valid), 0);

    // Reset in the middle of a division discards it.
    launch(800, 4, 1'b0);
    repeat (7) tick();
    #2 RST_N = 1'b0;
    #1;
    check_eq("t6_busy", 32'(oBUSY), 0);
    check_eq("t6_valid", 32'(oVALID), 0);
    check_eq("t6_coord", 32'(oCOORD), 0);
    check_eq("t6_flags", 32'({oZERO, oOVF}), 0);
    tick();
    RST_N = 1'b1;
    saw_valid = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (oVALID || oBUSY) saw_valid = 1'b1;
    end
    check_eq("t6_idle_after_rst", 32'(saw_valid), 0);

    run_one("post_rst", 65535, 255);
    for (int i = 0; i < 8; i++) begin
      int unsigned s, m;
      s = $urandom_range(65535, 0);
      m = (i == 3) ? 0 : $urandom_range(300, 1);
      run_one("rand", s, m);
    end

    repeat (3) tick();
    check_eq("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
